// File: rtl/data_bus_responder.sv
// -----------------------------------------------------------------------------
// data_bus_responder
//
// Sits on the single-cycle CPU data SRAM port and steers every access either to
// the backing data RAM or to a small confreg block. Read data is returned
// combinationally in the request cycle; writes commit on the rising clk edge.
//
// Confreg map (offset = addr[15:0], addr[1:0] ignored):
//   0x0000 LED        RW  {16'b0, led}
//   0x0004 SWITCH     RO  {24'b0, sw_sync}  (2-flop synchronised switch input)
//   0x0008 TIMER      RW  free-running 32-bit counter, write loads
//                         (built only when CONFREG_TIMER_EN is defined,
//                          otherwise the offset is unmapped)
//   0x000C UART_DATA  WO  push wdata[7:0] into the byte FIFO, reads 0
//   0x0010 UART_STAT  RW  {16'b0, count[7:0], 5'b0, ovf, full, empty};
//                         write with wdata[0]=1 clears the sticky ovf flag
//
// Optional feature macro: CONFREG_TIMER_EN
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   data_sram_we/addr/wdata/rdata    CPU data port (rdata combinational)
//   ram_we/addr/wdata/rdata          backing RAM port
//   led                              LED register
//   switch                           asynchronous switch inputs
//   uart_valid/uart_data/uart_ready  FIFO head byte, valid/ready handshake
// -----------------------------------------------------------------------------
module data_bus_responder #(
  parameter logic [15:0] CONF_BASE  = 16'h1fd0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch,
  output logic        uart_valid,
  output logic [7:0]  uart_data,
  input  logic        uart_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    SEL_LED,
    SEL_SWITCH,
    SEL_TIMER,
    SEL_UART_DATA,
    SEL_UART_STAT,
    SEL_NONE
  } reg_sel_e;

  logic        is_conf;
  logic        conf_we;
  reg_sel_e    reg_sel;
  logic [31:0] conf_rdata;

  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             empty;
  logic             full;
  logic             push_req;
  logic             push;
  logic             pop;

  // ---------------------------------------------------------------------------
  // Address decode and RAM passthrough
  // ---------------------------------------------------------------------------
  assign is_conf   = (data_sram_addr[31:16] == CONF_BASE);
  assign conf_we   = data_sram_we & is_conf;
  assign ram_we    = data_sram_we & ~is_conf;
  assign ram_addr  = data_sram_addr;
  assign ram_wdata = data_sram_wdata;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    reg_sel = SEL_NONE;
    case (data_sram_addr[15:2])
      14'h0000: reg_sel = SEL_LED;
      14'h0001: reg_sel = SEL_SWITCH;
`ifdef CONFREG_TIMER_EN
      14'h0002: reg_sel = SEL_TIMER;
`endif
      14'h0003: reg_sel = SEL_UART_DATA;
      14'h0004: reg_sel = SEL_UART_STAT;
      default:  reg_sel = SEL_NONE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // LED register and switch synchroniser
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      led     <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      if (conf_we && reg_sel == SEL_LED) led <= data_sram_wdata[15:0];
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

`ifdef CONFREG_TIMER_EN
  // ---------------------------------------------------------------------------
  // Free-running timer; a CPU write wins over the increment
  // ---------------------------------------------------------------------------
  logic [31:0] timer;

  always_ff @(posedge clk) begin
    if (reset)                               timer <= '0;
    else if (conf_we && reg_sel == SEL_TIMER) timer <= data_sram_wdata;
    else                                     timer <= timer + 32'd1;
  end
`endif

  // ---------------------------------------------------------------------------
  // UART byte FIFO
  // ---------------------------------------------------------------------------
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  // uart_valid comes from registered state only, never from uart_ready.
  assign uart_valid = ~empty;
  assign uart_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign pop        = uart_valid & uart_ready;
  assign push_req   = conf_we && (reg_sel == SEL_UART_DATA);
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push       = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_req && !push)
        ovf <= 1'b1;
      else if (conf_we && reg_sel == SEL_UART_STAT && data_sram_wdata[0])
        ovf <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; its contents are only
  // visible through uart_data, which is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_sram_wdata[7:0];
  end

  // ---------------------------------------------------------------------------
  // Confreg read mux and CPU read return
  // ---------------------------------------------------------------------------
  always_comb begin
    conf_rdata = '0;
    case (reg_sel)
      SEL_LED:       conf_rdata = {16'h0, led};
      SEL_SWITCH:    conf_rdata = {24'h0, sw_sync};
`ifdef CONFREG_TIMER_EN
      SEL_TIMER:     conf_rdata = timer;
`endif
      SEL_UART_STAT: conf_rdata = {16'h0, 8'(count), 5'h0, ovf, full, empty};
      default:       conf_rdata = '0;
    endcase
  end

  assign data_sram_rdata = is_conf ? conf_rdata : ram_rdata;

endmodule
